// File: rtl/arith_pkg.sv
// Shared definitions for the sequential divider: default width, FSM states
// and the iteration-counter width helper.
`timescale 1ns/1ps
package arith_pkg;

  // Default divisor/quotient/remainder width; the dividend is twice this.
  localparam int DW_DEF = 16;

  // Counter width able to hold 0..DW_DEF iterations.
  localparam int CNT_W = $clog2(DW_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter width for an arbitrary data width.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left by one,
// try to subtract the divisor, keep the difference and set the new quotient
// bit only when the subtraction does not go negative.
`timescale 1ns/1ps
module div_step #(
  parameter int DW = 16
) (
  input  logic [DW:0]   r_in,
  input  logic [DW-1:0] q_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   r_out,
  output logic [DW-1:0] q_out
);

  // Partial remainder after the shift; one spare bit so the compare never wraps.
  logic [DW+1:0] r_sh;
  logic [DW+1:0] div_ext;

  // Shift, trial-subtract and restore when the trial result would be negative.
  always_comb begin
    r_sh    = {r_in, q_in[DW-1]};
    div_ext = {2'b00, divisor};
    if (r_sh >= div_ext) begin
      r_out = (DW+1)'(r_sh - div_ext);
      q_out = {q_in[DW-2:0], 1'b1};
    end else begin
      r_out = (DW+1)'(r_sh);
      q_out = {q_in[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider32by16.sv
// Sequential radix-2 restoring divider: 2*DW-bit dividend by DW-bit divisor,
// one iteration per clock, valid/ready on both sides, one division in flight.
// Divide-by-zero and quotient overflow are detected up front and reported
// immediately without iterating.
`timescale 1ns/1ps
module seq_divider32by16
  import arith_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = cnt_width(DW);

  // Architectural state
  div_state_t    state_r,     state_nx;
  logic [CW-1:0] cnt_r,       cnt_nx;
  logic [DW:0]   rem_r,       rem_nx;
  logic [DW-1:0] quo_r,       quo_nx;
  logic [DW-1:0] dvs_r,       dvs_nx;

  // Registered outputs
  logic [DW-1:0] quotient_r,  quotient_nx;
  logic [DW-1:0] remainder_r, remainder_nx;
  logic          dbz_r,       dbz_nx;
  logic          ovf_r,       ovf_nx;
  logic          out_valid_r, out_valid_nx;
  logic          in_ready_r,  in_ready_nx;

  // Single iteration datapath
  logic [DW:0]   step_r;
  logic [DW-1:0] step_q;

  div_step #(.DW(DW)) u_step (
    .r_in    (rem_r),
    .q_in    (quo_r),
    .divisor (dvs_r),
    .r_out   (step_r),
    .q_out   (step_q)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    rem_nx       = rem_r;
    quo_nx       = quo_r;
    dvs_nx       = dvs_r;
    quotient_nx  = quotient_r;
    remainder_nx = remainder_r;
    dbz_nx       = dbz_r;
    ovf_nx       = ovf_r;
    out_valid_nx = out_valid_r;

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          dvs_nx       = divisor;
          dbz_nx       = 1'b0;
          ovf_nx       = 1'b0;
          out_valid_nx = 1'b0;
          if (divisor == {DW{1'b0}}) begin
            // Zero divisor wins over overflow.
            state_nx     = DONE;
            dbz_nx       = 1'b1;
            quotient_nx  = {DW{1'b1}};
            remainder_nx = dividend[DW-1:0];
            out_valid_nx = 1'b1;
          end else if (dividend[2*DW-1:DW] >= divisor) begin
            // High half >= divisor means the quotient needs more than DW bits.
            state_nx     = DONE;
            ovf_nx       = 1'b1;
            quotient_nx  = {DW{1'b1}};
            remainder_nx = dividend[DW-1:0];
            out_valid_nx = 1'b1;
          end else begin
            state_nx = CALC;
            rem_nx   = {1'b0, dividend[2*DW-1:DW]};
            quo_nx   = dividend[DW-1:0];
            cnt_nx   = {CW{1'b0}};
          end
        end else begin
          state_nx = IDLE;
        end
      end

      CALC: begin
        rem_nx = step_r;
        quo_nx = step_q;
        cnt_nx = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(DW - 1)) begin
          state_nx     = DONE;
          quotient_nx  = step_q;
          remainder_nx = step_r[DW-1:0];
          out_valid_nx = 1'b1;
        end else begin
          state_nx = CALC;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nx     = IDLE;
          out_valid_nx = 1'b0;
        end else begin
          state_nx = DONE;
        end
      end

      default: begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    endcase

    // in_ready is registered, so it reflects the state being entered.
    in_ready_nx = (state_nx == IDLE);
  end

  // State and output registers with synchronous reset discarding any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {(DW+1){1'b0}};
      quo_r       <= {DW{1'b0}};
      dvs_r       <= {DW{1'b0}};
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {DW{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      rem_r       <= rem_nx;
      quo_r       <= quo_nx;
      dvs_r       <= dvs_nx;
      quotient_r  <= quotient_nx;
      remainder_r <= remainder_nx;
      dbz_r       <= dbz_nx;
      ovf_r       <= ovf_nx;
      out_valid_r <= out_valid_nx;
      in_ready_r  <= in_ready_nx;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider32by16.sv
// Self-checking bench for seq_divider32by16: directed cases with literal
// expectations, randomized operands against an arithmetic reference model,
// backpressure and mid-operation reset.
`timescale 1ns/1ps
module tb_seq_divider32by16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  seq_divider32by16 #(.DW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division plus the error-case conventions.
  function automatic res_t model(input logic [31:0] a, input logic [15:0] b);
    res_t        m;
    logic [31:0] qq;
    logic [31:0] rr;
    if (b == 16'd0) begin
      m = '{q: 16'hFFFF, r: a[15:0], dbz: 1'b1, ovf: 1'b0};
    end else begin
      qq = a / {16'd0, b};
      rr = a % {16'd0, b};
      if (qq > 32'h0000FFFF)
        m = '{q: 16'hFFFF, r: a[15:0], dbz: 1'b0, ovf: 1'b1};
      else
        m = '{q: qq[15:0], r: rr[15:0], dbz: 1'b0, ovf: 1'b0};
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Scoreboard: whenever a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        check("sb_quotient",    {16'd0, quotient},    {16'd0, exp_q[0].q});
        check("sb_remainder",   {16'd0, remainder},   {16'd0, exp_q[0].r});
        check("sb_div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_q[0].dbz});
        check("sb_overflow",    {31'd0, overflow},    {31'd0, exp_q[0].ovf});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Issue one division, measure latency (edges after the accept edge until
  // out_valid is seen), stall the consumer for 'hold' cycles while offering
  // a competing input, then complete the output handshake.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input int hold,
                       output res_t got, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    got = '{q: quotient, r: remainder, dbz: div_by_zero, ovf: overflow};
    for (int i = 0; i < hold; i++) begin
      dividend = 32'h12345678;
      divisor  = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      check("out_valid_held",       {31'd0, out_valid}, 32'd1);
      check("no_accept_in_done",    exp_q.size(), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    res_t        got;
    res_t        pin;
    int          lat;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic [31:0] a;
    int          mode;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'd0;
    divisor   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_quotient",  {16'd0, quotient},    32'd0);
    check("rst_remainder", {16'd0, remainder},   32'd0);
    check("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    check("rst_ovf",       {31'd0, overflow},    32'd0);

    // Pin the model against hand-computed values
    pin = model(32'd100, 16'd7);
    check("model_100_7_q", {16'd0, pin.q}, 32'd14);
    check("model_100_7_r", {16'd0, pin.r}, 32'd2);
    pin = model(32'h00050000, 16'h0005);
    check("model_ovf_flag", {31'd0, pin.ovf}, 32'd1);

    // Directed: normal path, 16-edge latency
    do_op(32'h06260060, 16'h5678, 0, got, lat);
    check("d1_quotient",  {16'd0, got.q}, 32'h1234);
    check("d1_remainder", {16'd0, got.r}, 32'h0);
    check("d1_flags",     {30'd0, got.dbz, got.ovf}, 32'd0);
    check("d1_latency",   lat, 32'd16);

    do_op(32'd100, 16'd7, 0, got, lat);
    check("d2_quotient",  {16'd0, got.q}, 32'd14);
    check("d2_remainder", {16'd0, got.r}, 32'd2);

    do_op(32'hFFFE0001, 16'hFFFF, 0, got, lat);
    check("d3_quotient",  {16'd0, got.q}, 32'hFFFF);
    check("d3_remainder", {16'd0, got.r}, 32'h0);

    // Directed: error paths report in the cycle right after the accept edge
    do_op(32'h0000ABCD, 16'h0000, 0, got, lat);
    check("dz_flag",      {31'd0, got.dbz}, 32'd1);
    check("dz_ovf_clear", {31'd0, got.ovf}, 32'd0);
    check("dz_quotient",  {16'd0, got.q},   32'hFFFF);
    check("dz_remainder", {16'd0, got.r},   32'hABCD);
    check("dz_latency",   lat, 32'd0);

    do_op(32'h00050000, 16'h0005, 0, got, lat);
    check("ov_flag",      {31'd0, got.ovf}, 32'd1);
    check("ov_dbz_clear", {31'd0, got.dbz}, 32'd0);
    check("ov_quotient",  {16'd0, got.q},   32'hFFFF);
    check("ov_remainder", {16'd0, got.r},   32'h0);
    check("ov_latency",   lat, 32'd0);

    // Backpressure: 10 stalled cycles with a competing input offered
    do_op(32'd100, 16'd7, 10, got, lat);
    check("bp_quotient", {16'd0, got.q}, 32'd14);
    do_op(32'd1000, 16'd3, 0, got, lat);
    check("bp_next_quotient",  {16'd0, got.q}, 32'd333);
    check("bp_next_remainder", {16'd0, got.r}, 32'd1);

    // Reset after 8 iterations: result discarded, divider usable again
    dividend = 32'h06260060;
    divisor  = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("mrst_out_valid", {31'd0, out_valid},   32'd0);
    check("mrst_in_ready",  {31'd0, in_ready},    32'd1);
    check("mrst_quotient",  {16'd0, quotient},    32'd0);
    check("mrst_remainder", {16'd0, remainder},   32'd0);
    check("mrst_flags",     {30'd0, div_by_zero, overflow}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("mrst_no_result", {31'd0, out_valid}, 32'd0);
    end
    do_op(32'd100, 16'd7, 0, got, lat);
    check("mrst_after_q", {16'd0, got.q}, 32'd14);
    check("mrst_after_r", {16'd0, got.r}, 32'd2);

    // Randomized operands; the scoreboard checks each result
    for (int n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        b = 16'($urandom_range(1, 65535));
        q = 16'($urandom);
        r = 16'($urandom % {16'd0, b});
        a = {16'd0, q} * {16'd0, b} + {16'd0, r};
      end else if (mode < 8) begin
        a = $urandom;
        b = 16'($urandom);
      end else if (mode < 9) begin
        a = $urandom;
        b = 16'd0;
      end else begin
        b = 16'($urandom_range(1, 65535));
        a = {b, 16'($urandom)};
      end
      do_op(a, b, $urandom_range(0, 2), got, lat);
      if (got.dbz || got.ovf) check("rnd_err_latency", lat, 32'd0);
      else                    check("rnd_latency",     lat, 32'd16);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
